// File: rtl/arm_pkg.sv
// Shared ARM condition-field encodings and NZCV flag bit positions.
package arm_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // AL and NV resolve without looking at the flags.
  function automatic logic cond_uses_flags(input cond_e c);
    return !((c == COND_AL) || (c == COND_NV));
  endfunction

endpackage

// File: rtl/status_cond_unit_cond_eval.sv
// Combinational ARM condition decode: pass = cond holds for the given NZCV flags.
module cond_eval
  import arm_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_cond_unit.sv
// NZCV status register plus ID->EXE condition check.
// COND_FWD_EN: forward in-flight status_in to the check instead of stalling.
module status_cond_unit
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] status_in,
  input  logic       s_we,
  input  logic       freeze,
  input  logic       flush,
  input  logic [3:0] cond,
  input  logic       cond_valid,
  output logic [3:0] status_q,
  output logic       carry,
  output logic       exe_valid,
  output logic       hazard_stall
);

  logic [3:0] status_d;
  logic [3:0] eff_flags;
  logic       exe_valid_q;
  logic       exe_valid_d;
  logic       pass;

`ifdef COND_FWD_EN
  assign eff_flags    = s_we ? status_in : status_q;
  assign hazard_stall = 1'b0;
`else
  assign eff_flags    = status_q;
  assign hazard_stall = !rst & cond_valid & s_we & cond_uses_flags(cond_e'(cond));
`endif

  cond_eval u_cond_eval (
    .cond  (cond_e'(cond)),
    .flags (eff_flags),
    .pass  (pass)
  );

  always_comb begin
    status_d    = status_q;
    exe_valid_d = cond_valid & pass & !hazard_stall;
    if (s_we) begin
      status_d = status_in;
    end
  end

  // Flush only kills the instruction entering EXE; the flag write still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q    <= '0;
      exe_valid_q <= 1'b0;
    end else if (!freeze) begin
      status_q    <= status_d;
      exe_valid_q <= flush ? 1'b0 : exe_valid_d;
    end
  end

  assign exe_valid = exe_valid_q;
  assign carry     = status_q[FLAG_C];

endmodule

// File: tb/tb_status_cond_unit.sv
// Randomized + directed self-checking bench for status_cond_unit (both COND_FWD_EN builds).
module tb_status_cond_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] status_in = '0;
  logic       s_we = 1'b0;
  logic       freeze = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] cond = '0;
  logic       cond_valid = 1'b0;
  logic [3:0] status_q;
  logic       carry;
  logic       exe_valid;
  logic       hazard_stall;

  int unsigned tests = 0;
  int unsigned fails = 0;

`ifdef COND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  status_cond_unit dut (
    .clk          (clk),
    .rst          (rst),
    .status_in    (status_in),
    .s_we         (s_we),
    .freeze       (freeze),
    .flush        (flush),
    .cond         (cond),
    .cond_valid   (cond_valid),
    .status_q     (status_q),
    .carry        (carry),
    .exe_valid    (exe_valid),
    .hazard_stall (hazard_stall)
  );

  always #5 clk = ~clk;

  // Conditions come in complementary pairs: even code is the base test, odd inverts it.
  function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  function automatic bit ref_hazard(input bit r, input bit cv, input bit we, input logic [3:0] c);
    if (r || FWD) return 1'b0;
    return cv && we && (c < 4'd14);
  endfunction

  logic [3:0] m_status;
  bit         m_exe;
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    logic [3:0] f;
    if (rst) begin
      m_status = '0;
      m_exe    = 1'b0;
      m_live   = 1'b1;
    end else if (!freeze) begin
      f = (FWD && s_we) ? status_in : m_status;
      m_exe = flush ? 1'b0
            : (cond_valid && ref_pass(cond, f) && !ref_hazard(1'b0, cond_valid, s_we, cond));
      if (s_we) m_status = status_in;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("model.status_q", status_q, m_status);
      chk("model.carry", {3'b0, carry}, {3'b0, m_status[1]});
      chk("model.exe_valid", {3'b0, exe_valid}, {3'b0, m_exe});
      chk("model.hazard_stall", {3'b0, hazard_stall},
          {3'b0, ref_hazard(rst, cond_valid, s_we, cond)});
    end
  end

  task automatic tick(input bit r, input bit we, input logic [3:0] si, input bit fr,
                      input bit fl, input logic [3:0] c, input bit cv);
    @(negedge clk);
    #2;
    rst = r; s_we = we; status_in = si; freeze = fr; flush = fl; cond = c; cond_valid = cv;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then EQ with Z=0 must not pass.
    tick(1, 0, 4'h0, 0, 0, 4'b0000, 1);
    after_edge();
    tick(0, 0, 4'h0, 0, 0, 4'b0000, 1);
    chk("reset.status_q", status_q, 4'b0000);
    after_edge();
    chk("reset.exe_eq", {3'b0, exe_valid}, 4'd0);

    // Flag write then consume.
    tick(0, 1, 4'b0100, 0, 0, 4'b1110, 0);
    after_edge();
    chk("fw.status_q", status_q, 4'b0100);
    tick(0, 0, 4'h0, 0, 0, 4'b0000, 1);
    after_edge();
    chk("fw.exe_eq", {3'b0, exe_valid}, 4'd1);
    tick(0, 0, 4'h0, 0, 0, 4'b0001, 1);
    after_edge();
    chk("fw.exe_ne", {3'b0, exe_valid}, 4'd0);

    // Make GE fail on the stored flags so only the in-flight value can pass it.
    tick(0, 1, 4'b1000, 0, 0, 4'b0000, 0);
    after_edge();
    tick(0, 1, 4'b1001, 0, 0, 4'b1010, 1);
    #1;
    chk("b2b.hazard_c0", {3'b0, hazard_stall}, FWD ? 4'd0 : 4'd1);
    after_edge();
    chk("b2b.exe_c0", {3'b0, exe_valid}, FWD ? 4'd1 : 4'd0);
`ifndef COND_FWD_EN
    tick(0, 0, 4'h0, 0, 0, 4'b1010, 1);
    #1;
    chk("b2b.hazard_c1", {3'b0, hazard_stall}, 4'd0);
    after_edge();
    chk("b2b.exe_c1", {3'b0, exe_valid}, 4'd1);
`endif

    // Freeze beats flush and s_we; releasing freeze with flush clears exe_valid.
    tick(0, 1, 4'b1111, 1, 1, 4'b1110, 1);
    after_edge();
    chk("frz.status_q", status_q, 4'b1001);
    chk("frz.exe", {3'b0, exe_valid}, 4'd1);
    tick(0, 0, 4'h0, 0, 1, 4'b1110, 1);
    after_edge();
    chk("frz.flush_exe", {3'b0, exe_valid}, 4'd0);

    // Full sweep of 16 conditions x 16 flag patterns.
    for (int f = 0; f < 16; f++) begin
      tick(0, 1, 4'(f), 0, 0, 4'b1111, 0);
      for (int c = 0; c < 16; c++) begin
        tick(0, 0, 4'h0, 0, 0, 4'(c), 1);
        if (c >= 14) begin
          after_edge();
          chk(c == 14 ? "sweep.al" : "sweep.nv", {3'b0, exe_valid}, c == 14 ? 4'd1 : 4'd0);
        end
      end
    end

    // Random traffic, including occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, 4'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 4'($urandom),
           $urandom_range(0, 3) != 0);
    end

    tick(0, 0, 4'h0, 0, 0, 4'h0, 0);
    after_edge();
    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/status_cond_unit.md
STATUS_COND_UNIT -- requirements
Module: status_cond_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock and rst is the reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 status_in  in  4  {N,Z,C,V} from the ALU in the EXE stage (bit3=N, bit2=Z, bit1=C, bit0=V).
REQ-005 s_we  in  1  EXE-stage instruction has the S bit set and is valid; update the flags.
REQ-006 freeze  in  1  pipeline hold; all state SHALL keep its value.
REQ-007 flush  in  1  branch-taken flush of the ID/EXE boundary.
REQ-008 cond  in  4  ARM condition field of the ID-stage instruction.
REQ-009 cond_valid  in  1  the ID-stage instruction is valid.
REQ-010 status_q  out  4  architectural NZCV register.
REQ-011 carry  out  1  equals status_q[1]; the ALU uses it for ADC/SBC.
REQ-012 exe_valid  out  1  registered: the instruction entering EXE passed its condition.
REQ-013 hazard_stall  out  1  combinational stall request to the ID stage (COND_FWD_EN absent only).

Function
REQ-014 Condition evaluation SHALL be per ARM, on the effective flags F:
  - EQ 0000: Z.  NE 0001: !Z.  CS 0010: C.  CC 0011: !C.
  - MI 0100: N.  PL 0101: !N.  VS 0110: V.  VC 0111: !V.
  - HI 1000: C&!Z.  LS 1001: !C|Z.
  - GE 1010: N==V.  LT 1011: N!=V.  GT 1100: !Z&(N==V).  LE 1101: Z|(N!=V).
  - AL 1110: 1.  1111 (NV): 0.
REQ-015 At the rising edge with s_we=1 and freeze=0, status_q SHALL load status_in; otherwise status_q SHALL hold.
REQ-016 At the rising edge, exe_valid SHALL load cond_valid & pass(F) & !hazard_stall when freeze=0 and flush=0.
REQ-017 flush=1 (freeze=0) SHALL clear exe_valid at the next edge; status_q SHALL still update per REQ-015.
REQ-018 freeze=1 SHALL override flush and hold exe_valid and status_q unchanged.
REQ-019 The flags write (s_we) SHALL complete in one cycle; the updated flags SHALL be visible on status_q the cycle after s_we.
REQ-020 AL and NV SHALL never cause hazard_stall, because they do not depend on the flags.

Reset
REQ-021 rst=1 at an edge SHALL set status_q=4'b0000 and exe_valid=0.
REQ-022 rst SHALL take priority over freeze, flush and s_we.
REQ-023 hazard_stall SHALL be 0 while rst=1.
REQ-024 Reset asserted mid-stall SHALL drop the stall and discard the pending flag update.

Configuration
REQ-025 Macro COND_FWD_EN selects how an in-flight flag update reaches the condition check.
REQ-026 With COND_FWD_EN defined:
  - F = status_in when s_we=1, else F = status_q.
  - hazard_stall SHALL be tied to 0.
REQ-027 Without COND_FWD_EN:
  - F = status_q.
  - hazard_stall = cond_valid & s_we & cond not in {AL,NV}.
  - The stalled instruction SHALL be re-evaluated in the next cycle against the updated status_q.

Structure
REQ-028 A shared package arm_pkg SHALL hold the 4-bit condition encodings (COND_EQ..COND_NV) and the flag bit indices (FLAG_N, FLAG_Z, FLAG_C, FLAG_V).
REQ-029 Condition decode SHALL be a combinational sub-module cond_eval (inputs cond and flags, output pass), instantiated once.

Verification
REQ-030 Reset check: rst=1 for one edge, then cond=EQ with cond_valid=1 -> status_q=0000, next-edge exe_valid=0 (Z=0).
REQ-031 Flag write then consume:
  - Stimulus: s_we=1 with status_in=0100 for one edge, then cond=EQ.
  - Required: status_q=0100, then exe_valid=1.
  - Repeat with cond=NE: exe_valid=0.
REQ-032 Back-to-back dependency with COND_FWD_EN: s_we=1, status_in=1001 (N=1,V=1) and cond=GE in the same cycle -> hazard_stall=0, exe_valid=1 at the next edge.
REQ-033 Same stimulus as REQ-032 without COND_FWD_EN:
  - hazard_stall=1 in cycle 0 and exe_valid=0 at that edge.
  - Cycle 1 (s_we=0): hazard_stall=0 and exe_valid=1.
REQ-034 freeze=1 while s_we=1, status_in=1111 and flush=1 -> status_q and exe_valid unchanged; release of freeze with flush=1 -> exe_valid=0.
REQ-035 Full condition sweep: all 16 cond values against all 16 flag patterns -> exe_valid matches REQ-014 in every case, with NV always 0 and AL always 1.
